// File: rtl/conv33_window_if.sv
// ----------------------------------------------------------------------------
// conv33_window_if
//   Bundles the pixel input handshake and the window output bus of
//   conv33_window.
//   Handshake: a pixel transfers on a rising clk edge where pix_valid and
//   pix_ready are both high. pix_ready never depends on pix_valid.
//   conv33_en and done are single-cycle pulses with no backpressure.
//
//   master : pixel source / window sink (drives start, pix_in, pix_valid)
//   slave  : conv33_window (drives pix_ready, data_*, conv33_en, busy, done)
// ----------------------------------------------------------------------------
interface conv33_window_if #(
  parameter int DATA_W = 8
);
  logic                     start;
  logic signed [DATA_W-1:0] pix_in;
  logic                     pix_valid;
  logic                     pix_ready;
  logic signed [DATA_W-1:0] data_0_0, data_0_1, data_0_2;
  logic signed [DATA_W-1:0] data_1_0, data_1_1, data_1_2;
  logic signed [DATA_W-1:0] data_2_0, data_2_1, data_2_2;
  logic                     conv33_en;
  logic                     busy;
  logic                     done;

  modport master (
    output start, pix_in, pix_valid,
    input  pix_ready,
    input  data_0_0, data_0_1, data_0_2,
    input  data_1_0, data_1_1, data_1_2,
    input  data_2_0, data_2_1, data_2_2,
    input  conv33_en, busy, done
  );

  modport slave (
    input  start, pix_in, pix_valid,
    output pix_ready,
    output data_0_0, data_0_1, data_0_2,
    output data_1_0, data_1_1, data_1_2,
    output data_2_0, data_2_1, data_2_2,
    output conv33_en, busy, done
  );
endinterface

// File: rtl/conv33_window.sv
// ----------------------------------------------------------------------------
// conv33_window
//   Builds 3x3 windows from a raster stream of signed pixels using two line
//   buffers and a 3x3 shift register, and pulses conv33_en (latency 1 after
//   the accepting edge) for every valid window. done pulses with the final
//   window of a frame.
//
//   Optional build macro CONV33_STRIDE2_EN: when defined, only windows whose
//   (row-2) and (col-2) are both even are emitted; done still pulses one
//   cycle after the final pixel, alone if that position is not emitted.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   bus          conv33_window_if.slave (start, pixel handshake, window out)
//   dbg_state_o  1 when the FSM is in RUN, 0 in IDLE
// ----------------------------------------------------------------------------
module conv33_window #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  conv33_window_if.slave   bus,
  output logic             dbg_state_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     en_q;
  logic                     done_q;
  logic signed [DATA_W-1:0] win_q [3][3];
  // Line buffers: lb0 holds row r-2, lb1 holds row r-1 at each column.
  logic signed [DATA_W-1:0] lb0_q [IMG_W];
  logic signed [DATA_W-1:0] lb1_q [IMG_W];

  logic accept;
  logic last_pix;
  logic win_valid;

  assign accept   = (state_q == ST_RUN) && bus.pix_valid;
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

`ifdef CONV33_STRIDE2_EN
  // (row-2) even <=> row even, same for columns.
  assign win_valid = (row_q >= ROW_TWO) && (col_q >= COL_TWO) &&
                     !row_q[0] && !col_q[0];
`else
  assign win_valid = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end else begin
      col_d = col_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            // Shift left; the new right column comes from the line buffers
            // (older rows) and the incoming pixel (newest row). Columns
            // shifted in at col 0/1 belong to the previous row but are never
            // flagged valid.
            for (int r = 0; r < 3; r++) begin
              win_q[r][0] <= win_q[r][1];
              win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb0_q[col_q];
            win_q[1][2] <= lb1_q[col_q];
            win_q[2][2] <= bus.pix_in;
            col_q       <= col_d;
            row_q       <= row_d;
            en_q        <= win_valid;
            if (last_pix) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Line-buffer storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= bus.pix_in;
    end
  end

  assign bus.pix_ready = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.conv33_en = en_q;
  assign bus.done      = done_q;
  assign dbg_state_o   = (state_q == ST_RUN);

  assign bus.data_0_0 = win_q[0][0];
  assign bus.data_0_1 = win_q[0][1];
  assign bus.data_0_2 = win_q[0][2];
  assign bus.data_1_0 = win_q[1][0];
  assign bus.data_1_1 = win_q[1][1];
  assign bus.data_1_2 = win_q[1][2];
  assign bus.data_2_0 = win_q[2][0];
  assign bus.data_2_1 = win_q[2][1];
  assign bus.data_2_2 = win_q[2][2];

endmodule

// File: tb/tb_conv33_window.sv
// ----------------------------------------------------------------------------
// tb_conv33_window
//   Directed bench for conv33_window. Default build uses a 4x4 frame;
//   with CONV33_STRIDE2_EN defined it uses a 6x6 frame with stride 2.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv33_window;

`ifdef CONV33_STRIDE2_EN
  localparam int W = 6;
  localparam int H = 6;
  localparam int EXP_PULSES = 4;  // ceil(4/2)*ceil(4/2)
`else
  localparam int W = 4;
  localparam int H = 4;
  localparam int EXP_PULSES = 4;  // (4-2)*(4-2)
`endif
  localparam int NPIX = W * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  conv33_window_if #(.DATA_W(8)) bus ();

  conv33_window #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [71:0] exp_q[$];
  bit pend_en   = 1'b0;
  bit pend_done = 1'b0;
  int mrow, mcol;

  function automatic logic [7:0] pix_val(input int mode, input int r, input int c);
    if (mode == 1) return 8'hFF;
    return 8'(r * W + c + 1);
  endfunction

  function automatic logic [71:0] exp_win(input int mode, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], pix_val(mode, r - 2 + i, c - 2 + j)};
    return w;
  endfunction

  function automatic logic [71:0] obs_win();
    return {bus.data_0_0, bus.data_0_1, bus.data_0_2,
            bus.data_1_0, bus.data_1_1, bus.data_1_2,
            bus.data_2_0, bus.data_2_1, bus.data_2_2};
  endfunction

  // Compare outputs against what the previous accept predicted, then clear.
  task automatic check_outputs();
    logic [71:0] e;
    checks++;
    assert (bus.conv33_en === pend_en) else begin
      errors++; $error("FAIL conv33_en obs=%b exp=%b", bus.conv33_en, pend_en);
    end
    checks++;
    assert (bus.done === pend_done) else begin
      errors++; $error("FAIL done obs=%b exp=%b", bus.done, pend_done);
    end
    if (bus.conv33_en === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL extra_window obs=%h exp=none", obs_win());
      end else begin
        e = exp_q.pop_front();
        checks++;
        assert (obs_win() === e) else begin
          errors++; $error("FAIL window obs=%h exp=%h", obs_win(), e);
        end
      end
    end
    pend_en   = 1'b0;
    pend_done = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_accept(input int mode);
    bit v;
    v = (mrow >= 2) && (mcol >= 2);
`ifdef CONV33_STRIDE2_EN
    v = v && (mrow % 2 == 0) && (mcol % 2 == 0);
`endif
    pend_en   = v;
    pend_done = (mrow == H - 1) && (mcol == W - 1);
    if (v) exp_q.push_back(exp_win(mode, mrow, mcol));
    if (mcol == W - 1) begin mcol = 0; mrow++; end
    else mcol++;
  endtask

  task automatic start_frame();
    cycle();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    pulses = 0;
  endtask

  // Drives pixels; stops after stop_after accepts (or the full frame).
  // start is pulsed together with pixel index start_at.
  task automatic send_frame(input int mode, input bit toggle,
                            input int stop_after, input int start_at);
    int n;
    int guard;
    bit phase;
    n = 0; guard = 0; phase = 1'b0;
    mrow = 0; mcol = 0;
    while (n < NPIX && n != stop_after) begin
      cycle();
      if (toggle) begin
        checks++;
        assert (bus.busy === 1'b1) else begin
          errors++; $error("FAIL busy_in_frame obs=%b exp=1", bus.busy);
        end
      end
      if (toggle && phase) begin
        bus.pix_valid = 1'b0;
        bus.start     = 1'b0;
        phase         = 1'b0;
      end else begin
        phase         = 1'b1;
        bus.start     = (n == start_at);
        bus.pix_valid = 1'b1;
        bus.pix_in    = pix_val(mode, mrow, mcol);
        if (bus.pix_ready === 1'b1) begin
          model_accept(mode);
          n++;
        end
      end
      guard++;
      if (guard > 4 * NPIX + 20) begin
        checks++; errors++;
        $error("FAIL frame_timeout obs=%0d accepted exp=%0d", n, NPIX);
        break;
      end
    end
  endtask

  task automatic finish_frame();
    cycle();
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    repeat (2) cycle();
    checks++;
    assert (exp_q.size() === 0) else begin
      errors++; $error("FAIL missing_windows obs=%0d left exp=0", exp_q.size());
    end
    checks++;
    assert (pulses === EXP_PULSES) else begin
      errors++; $error("FAIL pulse_count obs=%0d exp=%0d", pulses, EXP_PULSES);
    end
    checks++;
    assert (bus.busy === 1'b0) else begin
      errors++; $error("FAIL busy_after_frame obs=%b exp=0", bus.busy);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert (bus.pix_ready === 1'b0) else begin
      errors++; $error("FAIL %s_pix_ready obs=%b exp=0", tag, bus.pix_ready);
    end
    checks++;
    assert (bus.busy === 1'b0) else begin
      errors++; $error("FAIL %s_busy obs=%b exp=0", tag, bus.busy);
    end
    checks++;
    assert (obs_win() === 72'h0) else begin
      errors++; $error("FAIL %s_data obs=%h exp=0", tag, obs_win());
    end
    checks++;
    assert (dbg_state === 1'b0) else begin
      errors++; $error("FAIL %s_state obs=%b exp=0", tag, dbg_state);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.start     = 1'b1;   // start during reset must lose
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (3) cycle();
    check_reset_state("reset");
    rst       = 1'b0;
    bus.start = 1'b0;
    cycle();
    check_reset_state("post_reset");

    // Frame of 1..N, pix_valid held high.
    start_frame();
    send_frame(0, 1'b0, -1, -1);
    finish_frame();

    // Same frame with pix_valid toggling; start coincides with the final accept.
    start_frame();
    send_frame(0, 1'b1, -1, NPIX - 1);
    finish_frame();
    checks++;
    assert (dbg_state === 1'b0) else begin
      errors++; $error("FAIL start_on_last_accept obs=%b exp=0", dbg_state);
    end

    // All pixels -1.
    start_frame();
    send_frame(1, 1'b0, -1, -1);
    finish_frame();

    // Reset after 10 accepted pixels; then pix_valid driven while idle.
    start_frame();
    send_frame(0, 1'b0, 10, -1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_state("mid_reset");
    repeat (4) begin
      cycle();
      checks++;
      assert (bus.pix_ready === 1'b0 && dbg_state === 1'b0) else begin
        errors++; $error("FAIL idle_ignore obs=%b/%b exp=0/0", bus.pix_ready, dbg_state);
      end
    end
    checks++;
    assert (exp_q.size() === 0) else begin
      errors++; $error("FAIL mid_reset_windows obs=%0d exp=0", exp_q.size());
    end

    // Fresh frame, with start pulsed again mid-frame.
    bus.pix_valid = 1'b0;
    start_frame();
    send_frame(0, 1'b0, -1, 5);
    finish_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv33_window.md
Name: conv33_window

Overview:
- Window generator feeding conv33_calc.
- Accepts signed 8-bit pixels in raster order, one feature-map channel at a time.
- Keeps two line buffers and a 3x3 shift window, then drives data_r_c plus a one-cycle conv33_en pulse for every valid (unpadded) 3x3 position.
- Sits between the feature-map memory reader and conv33_calc; weights and bias are not handled here.

Parameters:
- IMG_W, 28, pixels per row (>=3)
- IMG_H, 28, rows per frame (>=3)
- DATA_W, 8, pixel width, signed two's complement

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- pix_in  in  DATA_W  signed input pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts pixel this cycle
- data_0_0..data_2_2  out  DATA_W each (9 ports)  window; row 0 = oldest row, col 0 = leftmost
- conv33_en  out  1  one-cycle pulse: window on data_* is valid
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on the final window of a frame

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values: pix_ready=0, conv33_en=0, busy=0, done=0, all data_*=0, col/row counters=0, FSM=IDLE.
- Line-buffer RAM contents are not reset.
- FSM states:
  - IDLE: start -> RUN, clearing col/row counters. pix_valid is ignored. pix_ready=0.
  - RUN: pix_ready=1, busy=1. start is ignored. Accept = pix_valid && pix_ready.
  - On accept of the last pixel (row=IMG_H-1, col=IMG_W-1): -> IDLE. done pulses together with that pixel's conv33_en, one cycle later.
- Accept at (row, col):
  - Window shifts left by one column.
  - New right column = {lb0[col], lb1[col], pix_in} for rows 0, 1, 2.
  - lb0[col] <= lb1[col]; lb1[col] <= pix_in.
  - col increments and wraps to 0 at IMG_W-1; row increments on wrap.
- Window validity: an accept with row>=2 && col>=2 produces a valid window. conv33_en goes high the next cycle (latency 1) with the updated window on data_*.
- data_* hold their value until the next accept. conv33_calc may sample them on the conv33_en cycle only.
- Windows must not span rows. The shift at col 0/1 loads stale columns; validity gating suppresses them.
- Frame output: exactly (IMG_W-2)*(IMG_H-2) conv33_en pulses, raster order.
- Backpressure: none from downstream. conv33_calc accepts one window per cycle. Gaps in pix_valid simply delay output.
- Arithmetic: none. Values are passed through bit-exact, sign preserved.
- Boundary cases:
  - Simultaneous start and rst: rst wins.
  - rst mid-frame: returns to IDLE immediately; no further conv33_en or done.
  - A new start is required for the next frame.
  - start in the same cycle as the final accept is ignored.

Optional Feature:
- Macro CONV33_STRIDE2_EN.
- Defined: stride 2. A valid window is emitted only when (row-2) and (col-2) are both even, giving ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2) pulses. done still coincides with the last pixel's cycle. If the last position is not emitted, done pulses alone, one cycle after the final accept.
- Undefined: stride 1 as described above.

Test Plan:
1. IMG_W=IMG_H=4, pixels 1..16, pix_valid held high -> 4 conv33_en pulses. First pulse 1 cycle after accepting pixel 11, window rows (1,2,3)(5,6,7)(9,10,11). Last window (6,7,8)(10,11,12)(14,15,16), with done high on the same cycle.
2. Same frame with pix_valid toggled 1/0 every cycle -> identical 4 windows in the same order; no pulse on idle cycles; busy high throughout.
3. All pixels -1, 4x4 -> every data_* on each pulse = 8'hFF (signed -1). Into conv33_calc with all-ones weights, result = -9.
4. rst asserted after 10 of 16 pixels -> next cycle pix_ready=0, busy=0, data_*=0. No conv33_en afterwards. A fresh start with pixels 1..16 reproduces scenario 1 exactly.
5. start pulsed again mid-frame and pix_valid driven while in IDLE -> no effect. Counters are unchanged and no pixel is accepted in IDLE.
6. CONV33_STRIDE2_EN defined, IMG_W=IMG_H=6, pixels 1..36 -> 4 pulses with top-left elements 1, 3, 13, 15. The final one is window (15,16,17)(21,22,23)(27,28,29). done pulses 1 cycle after pixel 36 is accepted.
